// File: rtl/lcd_irct_pkg.sv
// Shared types and plane-layout helpers for the LCD inverse-RCT read scheduler.
package lcd_irct_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_Y  = 3'd1,
    ST_RD_CB = 3'd2,
    ST_RD_CR = 3'd3,
    ST_LAST  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PLANE_Y  = 2'd0,
    PLANE_CB = 2'd1,
    PLANE_CR = 2'd2
  } plane_t;

  localparam int unsigned PIX_PER_WORD = 2;
  localparam int unsigned STALL_CNT_W  = 16;

  function automatic int unsigned plane_words(input int unsigned img_w,
                                              input int unsigned img_h);
    return (img_w * img_h) / PIX_PER_WORD;
  endfunction

  // Planes are stacked Y, Cb, Cr in the frame buffer.
  function automatic int unsigned plane_base(input plane_t p, input int unsigned pw);
    case (p)
      PLANE_CB: return pw;
      PLANE_CR: return 2 * pw;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/lcd_irct_addr_gen.sv
// Word-index counter and frame-buffer address generator for the inverse-RCT scheduler.
module lcd_irct_addr_gen
  import lcd_irct_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned PLANE_WORDS = 38400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  plane_t            plane_sel,
  input  logic              widx_inc,
  input  logic              widx_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              last_word
);

  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] addr_comb;
  logic [ADDR_W-1:0] addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx <= '0;
    end else if (widx_clr) begin
      widx <= '0;
    end else if (widx_inc) begin
      widx <= widx + ADDR_W'(1);
    end
  end

  always_comb begin
    addr_comb = ADDR_W'(plane_base(plane_sel, PLANE_WORDS)) + widx;
  end

  // Address is live during reads and frozen at the last read address otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold <= '0;
    end else if (rd_en) begin
      addr_hold <= addr_comb;
    end
  end

  assign mem_addr  = rd_en ? addr_comb : addr_hold;
  assign last_word = (widx == ADDR_W'(PLANE_WORDS - 1));

endmodule

// File: rtl/lcd_irct_scheduler.sv
// Frame read sequencer feeding {Y,Cb,Cr} pixel pairs to the inverse-RCT stage.
// Optional stall counter port enabled by LCD_IRCT_SCHED_PERF_EN.
module lcd_irct_scheduler
  import lcd_irct_pkg::*;
#(
  parameter int unsigned WAVE_PIX_W = 10,
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [2*WAVE_PIX_W-1:0] mem_rdata,
  input  logic                    fifo_afull,
  output logic                    rct_valid,
  output logic [WAVE_PIX_W-1:0]   y0,
  output logic [WAVE_PIX_W-1:0]   cb0,
  output logic [WAVE_PIX_W-1:0]   cr0,
  output logic [WAVE_PIX_W-1:0]   y1,
  output logic [WAVE_PIX_W-1:0]   cb1,
  output logic [WAVE_PIX_W-1:0]   cr1
`ifdef LCD_IRCT_SCHED_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cnt
`endif
);

  localparam int unsigned PLANE_WORDS = plane_words(IMG_W, IMG_H);
  localparam int unsigned W           = WAVE_PIX_W;

  state_t state, next_state;
  plane_t plane_sel;

  logic accept;
  logic pending;
  logic last_word;
  logic widx_inc, widx_clr;
  logic cap_y, cap_cb, emit, finish;
  logic [2*W-1:0] hold_y, hold_cb;

  // A start coinciding with frame_done is dropped along with starts while busy.
  assign accept  = start && !busy && !frame_done;
  assign pending = (state == ST_IDLE) && busy;

  lcd_irct_addr_gen #(
    .ADDR_W      (ADDR_W),
    .PLANE_WORDS (PLANE_WORDS)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (mem_rd_en),
    .plane_sel (plane_sel),
    .widx_inc  (widx_inc),
    .widx_clr  (widx_clr),
    .mem_addr  (mem_addr),
    .last_word (last_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A stalled LAST exits to IDLE with busy still set; that pending state
  // re-enters RD_Y once the FIFO drains.
  always_comb begin
    next_state = state;
    mem_rd_en  = 1'b0;
    plane_sel  = PLANE_Y;
    widx_inc   = 1'b0;
    widx_clr   = 1'b0;
    cap_y      = 1'b0;
    cap_cb     = 1'b0;
    emit       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          widx_clr = 1'b1;
        end
        if ((accept || pending) && !fifo_afull) begin
          next_state = ST_RD_Y;
        end
      end
      ST_RD_Y: begin
        mem_rd_en  = 1'b1;
        plane_sel  = PLANE_Y;
        next_state = ST_RD_CB;
      end
      ST_RD_CB: begin
        mem_rd_en  = 1'b1;
        plane_sel  = PLANE_CB;
        cap_y      = 1'b1;
        next_state = ST_RD_CR;
      end
      ST_RD_CR: begin
        mem_rd_en  = 1'b1;
        plane_sel  = PLANE_CR;
        cap_cb     = 1'b1;
        next_state = ST_LAST;
      end
      ST_LAST: begin
        emit = 1'b1;
        if (last_word) begin
          widx_clr   = 1'b1;
          finish     = 1'b1;
          next_state = ST_IDLE;
        end else begin
          widx_inc   = 1'b1;
          next_state = fifo_afull ? ST_IDLE : ST_RD_Y;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rct_valid  <= 1'b0;
    end else begin
      if (accept) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end
      frame_done <= finish;
      rct_valid  <= emit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_y  <= '0;
      hold_cb <= '0;
    end else begin
      if (cap_y) begin
        hold_y <= mem_rdata;
      end
      if (cap_cb) begin
        hold_cb <= mem_rdata;
      end
    end
  end

  // Cr bypasses the holding stage: it arrives in LAST and goes straight out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0  <= '0;
      y1  <= '0;
      cb0 <= '0;
      cb1 <= '0;
      cr0 <= '0;
      cr1 <= '0;
    end else if (emit) begin
      y0  <= hold_y[W-1:0];
      y1  <= hold_y[2*W-1:W];
      cb0 <= hold_cb[W-1:0];
      cb1 <= hold_cb[2*W-1:W];
      cr0 <= mem_rdata[W-1:0];
      cr1 <= mem_rdata[2*W-1:W];
    end
  end

`ifdef LCD_IRCT_SCHED_PERF_EN
  logic held;

  assign held = busy && fifo_afull &&
                ((state == ST_IDLE) || ((state == ST_LAST) && !last_word));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (held && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/lcd_irct_scheduler.md
Name: lcd_irct_scheduler

Overview:
Frame-level read sequencer that feeds the LCD inverse-RCT datapath from the wavelet-domain frame buffer. Walks the Y, Cb and Cr coefficient planes of one frame through a single shared read port (1-cycle read latency). Unpacks two pixels per word and presents complete {Y,Cb,Cr} pixel pairs with a one-cycle valid strobe. Throttles on the downstream LCD FIFO almost-full flag, because the inverse-RCT stage itself has no backpressure.

Parameters:
WAVE_PIX_W, 10, coefficient width (two's complement), per pixel
IMG_W, 320, frame width in pixels (even)
IMG_H, 240, frame height in lines
ADDR_W, 17, frame-buffer word address width; must hold 3*PLANE_WORDS-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  frame start request, one-cycle pulse
busy  out  1  high while a frame is in progress
frame_done  out  1  one-cycle pulse when the last pair has been issued
mem_rd_en  out  1  frame-buffer read strobe
mem_addr  out  ADDR_W  frame-buffer word address
mem_rdata  in  2*WAVE_PIX_W  read data, valid the cycle after mem_rd_en; [W-1:0]=pixel0, [2W-1:W]=pixel1
fifo_afull  in  1  downstream LCD FIFO almost full
rct_valid  out  1  pixel-pair valid to inverse RCT (drives its in_valid)
y0, cb0, cr0  out  WAVE_PIX_W each  pixel-0 coefficients
y1, cb1, cr1  out  WAVE_PIX_W each  pixel-1 coefficients

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Derived constant: PLANE_WORDS = IMG_W*IMG_H/2.
- Plane bases: Y at 0, Cb at PLANE_WORDS, Cr at 2*PLANE_WORDS.
- Word index widx runs 0..PLANE_WORDS-1.
- Reset values: all outputs 0 (busy, frame_done, mem_rd_en, mem_addr, rct_valid, all coefficient outputs). FSM goes to IDLE, widx to 0.
- Reset mid-frame aborts immediately. No frame_done is generated, and the next start begins again at widx 0.
- FSM states: IDLE, RD_Y, RD_CB, RD_CR, LAST.
  - IDLE: start=1 sets busy and moves to RD_Y, or to WAIT-equivalent hold in IDLE-busy if fifo_afull (see gating rule).
  - RD_Y: mem_rd_en=1, mem_addr=widx. Go to RD_CB.
  - RD_CB: mem_rd_en=1, mem_addr=PLANE_WORDS+widx. Capture mem_rdata as Y pair. Go to RD_CR.
  - RD_CR: mem_rd_en=1, mem_addr=2*PLANE_WORDS+widx. Capture Cb pair. Go to LAST.
  - LAST: mem_rd_en=0. Capture Cr pair directly into the cr outputs. Load y/cb outputs from holding registers, and register rct_valid=1 for the next cycle.
    - If widx==PLANE_WORDS-1: clear widx, register frame_done=1, go to IDLE.
    - Otherwise: increment widx and go to RD_Y.
- Gating: a new pair read sequence, i.e. entry into RD_Y, occurs only when fifo_afull=0. If fifo_afull=1, the FSM stalls in an internal pending condition (IDLE with busy=1, or LAST-exit held) with mem_rd_en=0.
  - A sequence already started always completes; fifo_afull is ignored inside RD_Y..LAST.
- Throughput: 4 cycles per pixel pair when unstalled. Latency is 4 cycles from RD_Y to rct_valid high.
- rct_valid is high exactly one cycle per pair. Coefficient outputs hold their last value while rct_valid=0.
- frame_done is high in the same cycle as the final rct_valid. busy drops in that same cycle.
- start while busy=1 is ignored. start in the same cycle as frame_done is ignored.
- Data is passed bit-exact with no sign manipulation; sign handling belongs to the inverse-RCT stage.
- mem_addr holds its last value when mem_rd_en=0.

Optional Feature:
LCD_IRCT_SCHED_PERF_EN
- Defined: adds output stall_cnt [15:0], counting cycles where busy=1 and the FSM is held by fifo_afull. It saturates at 16'hFFFF, clears on start acceptance, and resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package lcd_irct_pkg holds:
  - FSM state enum (3-bit encoding)
  - PLANE_WORDS computation and plane-base constants
  - plane-select encoding (PLANE_Y/CB/CR)
- One sub-module, lcd_irct_addr_gen: holds widx, generates mem_addr from plane select, and flags last-word. The FSM and unpack registers stay in the top.

Test Plan:
- Basic frame: IMG_W=4, IMG_H=2, fifo_afull=0, memory word a holds {a+100, a} -> exactly 12 reads at addrs 0,4,8,1,5,9,...,3,7,11.
  - First rct_valid 4 cycles after RD_Y with y0=0, y1=100, cb0=4, cb1=104, cr0=8, cr1=108.
  - 4 valid pulses total; frame_done coincides with the 4th.
- Backpressure: raise fifo_afull during RD_CB of pair 1 -> pair 1 still completes; no RD_Y until fifo_afull falls. stall_cnt (PERF_EN) equals the held cycles.
- Negative data: word {10'h3FF, 10'h200} in all planes -> outputs y0=cb0=cr0=10'h200 and y1=cb1=cr1=10'h3FF, unchanged.
- start during busy: pulse start at pair 2 -> no restart; exactly one frame_done; total reads still 12.
- Reset mid-frame: assert rst_n=0 in RD_CR of pair 3 -> all outputs 0 asynchronously. The next start reads address 0 first; no stray frame_done.
- Back-to-back frames: start in the cycle after frame_done -> second frame identical to the first; widx restarts at 0.
